// File: rtl/cd_pkg.sv
// Shared constants and helpers for the cd_rx_ring receive frame buffer.
package cd_pkg;

    localparam logic [7:0] CD_LOST_MAX = 8'hFF;

    // Bit width needed to index 'value' entries; never less than 1.
    function automatic int cd_clog2(input int value);
        int w;
        w = 0;
        for (int i = 1; i < value; i = i * 2) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/cd_ram_1r1w.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module cd_ram_1r1w
    import cd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wr_en,
    input  logic [cd_clog2(DEPTH)-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic                        i_rd_en,
    input  logic [cd_clog2(DEPTH)-1:0]  i_rd_addr,
    output logic [DATA_W-1:0]           o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cd_rx_ring.sv
// Multi-page receive frame ring: FIFO of committed frames plus one fill page,
// with drop-oldest overflow mode and a saturating lost-frame counter.
module cd_rx_ring
    import cd_pkg::*;
#(
    parameter int PAGES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  wr_byte,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_flags,
    input  logic                        switch,
    input  logic                        drop_oldest,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [7:0]                  rd_byte,
    output logic [7:0]                  rd_flags,
    input  logic                        rd_done,
    input  logic                        rd_done_all,
    output logic                        unread,
    output logic [cd_clog2(PAGES)-1:0]  unread_cnt,
    output logic                        switch_fail,
    output logic [7:0]                  lost_cnt,
    input  logic                        clr_lost
);

    localparam int PW = cd_clog2(PAGES);
    localparam logic [PW-1:0] FULL_CNT = PW'(PAGES - 1);
    localparam logic [PW-1:0] ONE      = PW'(1);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_cnt;
    logic [7:0]    r_flags [PAGES];
    logic          r_fail;
    logic [7:0]    r_lost;

    logic          w_rel, w_full_mid, w_store, w_fail, w_loss;
    logic [PW-1:0] w_cnt_mid, w_rd_mid;
    logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;
    logic [7:0]    w_lost_base, w_lost_nxt;

    // Release/flush is resolved first so a commit sees the freed slot.
    // NOTE: every signal gets a default at the top so no latch is inferred.
    always_comb begin
        w_rel     = rd_done && !rd_done_all && (r_cnt != '0);
        w_cnt_mid = r_cnt;
        w_rd_mid  = r_rd_ptr;
        if (rd_done_all) begin
            w_cnt_mid = '0;
            w_rd_mid  = r_wr_ptr;
        end else if (w_rel) begin
            w_cnt_mid = r_cnt - ONE;
            w_rd_mid  = r_rd_ptr + ONE;
        end
        w_full_mid = (w_cnt_mid == FULL_CNT);

        w_wr_nxt  = r_wr_ptr;
        w_rd_nxt  = w_rd_mid;
        w_cnt_nxt = w_cnt_mid;
        w_store   = 1'b0;
        w_fail    = 1'b0;
        w_loss    = 1'b0;
        if (switch) begin
            if (!w_full_mid) begin
                w_store   = 1'b1;
                w_wr_nxt  = r_wr_ptr + ONE;
                w_cnt_nxt = w_cnt_mid + ONE;
            end else if (!drop_oldest) begin
                w_fail = 1'b1;
                w_loss = 1'b1;
            end else begin
                w_store  = 1'b1;
                w_wr_nxt = r_wr_ptr + ONE;
                w_rd_nxt = w_rd_mid + ONE;
                w_loss   = 1'b1;
            end
        end

        w_lost_base = clr_lost ? 8'h00 : r_lost;
        w_lost_nxt  = w_lost_base;
        if (w_loss && (w_lost_base != CD_LOST_MAX)) begin
            w_lost_nxt = w_lost_base + 8'h01;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_fail   <= 1'b0;
            r_lost   <= '0;
            for (int i = 0; i < PAGES; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fail   <= w_fail;
            r_lost   <= w_lost_nxt;
            if (w_store) begin
                r_flags[r_wr_ptr] <= wr_flags;
            end
        end
    end

    cd_ram_1r1w #(
        .DATA_W (8),
        .DEPTH  (PAGES * (2 ** ADDR_W))
    ) u_ram (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (wr_en),
        .i_wr_addr ({r_wr_ptr, wr_addr}),
        .i_wr_data (wr_byte),
        .i_rd_en   (rd_en),
        .i_rd_addr ({r_rd_ptr, rd_addr}),
        .o_rd_data (rd_byte)
    );

    assign rd_flags    = r_flags[r_rd_ptr];
    assign unread      = (r_cnt != '0);
    assign unread_cnt  = r_cnt;
    assign switch_fail = r_fail;
    assign lost_cnt    = r_lost;

endmodule
